// File: rtl/countdown_timer_pkg.sv
// Shared definitions for the countdown timer: status encodings, count limits,
// preset clamping helpers and the counter control strobe bundle.
package countdown_timer_pkg;

  localparam int unsigned MAX_SEC = 59;
  localparam int unsigned MAX_MIN = 99;

  // The state encoding is also the externally visible status code.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_RUNNING = 2'b01,
    ST_PAUSED  = 2'b10,
    ST_EXPIRED = 2'b11
  } state_t;

  // Strobes from the control FSM to the counter. Priority is clear > load > dec.
  typedef struct packed {
    logic clear;
    logic load;
    logic dec;
  } cnt_ctl_t;

  function automatic logic [7:0] clamp_min(input logic [7:0] m);
    return (m > 8'(MAX_MIN)) ? 8'(MAX_MIN) : m;
  endfunction

  function automatic logic [5:0] clamp_sec(input logic [5:0] s);
    return (s > 6'(MAX_SEC)) ? 6'(MAX_SEC) : s;
  endfunction

endpackage

// File: rtl/countdown_counter.sv
// mm:ss register pair for the countdown timer.
//   clk, rst_n          : clock, async active-low reset
//   ctl                 : clear / load / dec strobes from the control FSM
//   preset_min/sec      : load values, clamped to 99:59 on capture
//   minutes, seconds    : current count
//   zero                : count is 00:00
//   last                : count is 00:01, so a decrement lands on 00:00
module countdown_counter
  import countdown_timer_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  cnt_ctl_t   ctl,
  input  logic [7:0] preset_min,
  input  logic [5:0] preset_sec,
  output logic [7:0] minutes,
  output logic [5:0] seconds,
  output logic       zero,
  output logic       last
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      minutes <= '0;
      seconds <= '0;
    end else if (ctl.clear) begin
      minutes <= '0;
      seconds <= '0;
    end else if (ctl.load) begin
      minutes <= clamp_min(preset_min);
      seconds <= clamp_sec(preset_sec);
    end else if (ctl.dec) begin
      if (seconds != '0) begin
        seconds <= seconds - 6'd1;
      end else if (minutes != '0) begin
        // Borrow a minute.
        seconds <= 6'(MAX_SEC);
        minutes <= minutes - 8'd1;
      end
    end
  end

  assign zero = (minutes == '0) && (seconds == '0);
  assign last = (minutes == '0) && (seconds == 6'd1);

endmodule

// File: rtl/countdown_timer.sv
// Countdown timer: control FSM around a mm:ss counter.
//   clk, rst_n             : clock, async active-low reset
//   tick                   : one-second strobe, decrements while RUNNING
//   start / stop / reset   : commands, priority reset > stop > load > start
//   load, preset_min/sec   : capture a preset (IDLE only), clamped to 99:59
//   minutes, seconds       : registered count
//   status                 : 00 IDLE, 01 RUNNING, 10 PAUSED, 11 EXPIRED
//   expired                : one-cycle pulse coincident with entering EXPIRED
module countdown_timer
  import countdown_timer_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       start,
  input  logic       stop,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] preset_min,
  input  logic [5:0] preset_sec,
  output logic [7:0] minutes,
  output logic [5:0] seconds,
  output logic [1:0] status,
  output logic       expired
);

  state_t   state, state_nxt;
  cnt_ctl_t ctl;
  logic     exp_nxt;
  logic     zero, last;

  countdown_counter u_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .ctl        (ctl),
    .preset_min (preset_min),
    .preset_sec (preset_sec),
    .minutes    (minutes),
    .seconds    (seconds),
    .zero       (zero),
    .last       (last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      expired <= 1'b0;
    end else begin
      state   <= state_nxt;
      expired <= exp_nxt;
    end
  end

  // A higher-priority command masks lower ones even when it has no effect in
  // the current state (e.g. stop in IDLE blocks load, load in PAUSED blocks start).
  always_comb begin
    state_nxt = state;
    ctl       = '0;
    exp_nxt   = 1'b0;
    if (reset) begin
      ctl.clear = 1'b1;
      state_nxt = ST_IDLE;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (!stop) begin
            if (load)
              ctl.load = 1'b1;
            else if (start && !zero)
              state_nxt = ST_RUNNING;
          end
        end
        ST_RUNNING: begin
          // stop wins over a same-cycle tick; load is ignored here.
          if (stop) begin
            state_nxt = ST_PAUSED;
          end else if (tick) begin
            ctl.dec = 1'b1;
            if (last) begin
              state_nxt = ST_EXPIRED;
              exp_nxt   = 1'b1;
            end
          end
        end
        ST_PAUSED: begin
          if (!stop && !load && start)
            state_nxt = ST_RUNNING;
        end
        ST_EXPIRED: begin
          // Count already 00:00; only reset leaves.
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  assign status = state;

endmodule
